// File: rtl/mat_fifo_loader.sv
// Streams a row-major A matrix and then vector B into the operand FIFO bank,
// then sequences the multiplier through clear, enable and done.
module mat_fifo_loader #(
  parameter int DATA_W = 8,
  parameter int DIM    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic [DIM:0]      fifo_wren,
  input  logic [DIM:0]      fifo_full,
  output logic              mult_clr,
  output logic              mult_en,
  input  logic              mult_done,
  output logic              busy,
  output logic              job_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // CLEAR  | one-cycle accumulator clear, counters zeroed
  // LOAD_A | streaming A row-major into FIFOs 1..DIM
  // LOAD_B | streaming B into FIFO 0
  // FIRE   | one-cycle multiplier enable
  // WAIT   | waiting for mult_done (first cycle ignores it)

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW = $clog2(DIM + 1);
  localparam logic [CW-1:0] LAST    = CW'(DIM - 1);
  localparam logic [DIM:0]  WREN_LSB = {{DIM{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    FIRE   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] tgt;
  logic          loading;
  logic          hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      armed_q <= armed_d;
    end
  end

  // Write path is purely combinational so a handshake writes in the same cycle.
  always_comb begin
    loading    = (state_q == LOAD_A) || (state_q == LOAD_B);
    tgt        = (state_q == LOAD_A) ? (TW'(row_q) + TW'(1)) : '0;
    in_ready   = loading && !fifo_full[tgt];
    hs         = in_valid && in_ready;
    fifo_wren  = hs ? (WREN_LSB << tgt) : '0;
    fifo_wdata = loading ? in_data : '0;
    busy       = (state_q != IDLE);
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    armed_d  = armed_q;
    mult_clr = 1'b0;
    mult_en  = 1'b0;
    job_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        mult_clr = 1'b1;
        row_d    = '0;
        col_d    = '0;
        state_d  = LOAD_A;
      end
      LOAD_A: begin
        if (hs) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) state_d = LOAD_B;
            else               row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (hs) begin
          if (col_q == LAST) begin
            col_d   = '0;
            state_d = FIRE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FIRE: begin
        mult_en = 1'b1;
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done left over from before loading must not end the job.
        armed_d = 1'b1;
        if (armed_q && mult_done) begin
          job_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mat_fifo_loader.sv
// Randomized bench for mat_fifo_loader: a stream-index reference model is
// compared against the DUT every cycle, plus per-job totals and FIFO contents.
module tb_mat_fifo_loader;
  localparam int DW    = 8;
  localparam int DIM   = 8;
  localparam int NA    = DIM * DIM;
  localparam int TOTAL = NA + DIM;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, mult_clr, mult_en, mult_done;
  logic          busy, job_done;
  logic [DW-1:0] in_data, fifo_wdata;
  logic [DIM:0]  fifo_wren, fifo_full;

  mat_fifo_loader #(.DATA_W(DW), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .fifo_wdata(fifo_wdata),
    .fifo_wren(fifo_wren), .fifo_full(fifo_full), .mult_clr(mult_clr),
    .mult_en(mult_en), .mult_done(mult_done), .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase plus count of accepted stream bytes.
  // phase 0 idle, 1 clear, 2 loading, 3 fire, 4 waiting for done.
  int m_phase = 0;
  int m_k = 0;
  int m_wait = 0;

  function automatic int tgt_of(input int k);
    return (k < NA) ? (k / DIM + 1) : 0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_phase <= 0;
      m_k     <= 0;
      m_wait  <= 0;
    end else begin
      case (m_phase)
        0: if (start) m_phase <= 1;
        1: begin m_phase <= 2; m_k <= 0; end
        2: if (in_valid && !fifo_full[tgt_of(m_k)]) begin
             m_k <= m_k + 1;
             if (m_k + 1 == TOTAL) m_phase <= 3;
           end
        3: begin m_phase <= 4; m_wait <= 0; end
        default: if (m_wait >= 1 && mult_done) m_phase <= 0;
                 else m_wait <= m_wait + 1;
      endcase
    end
  end

  // Event counters and captured FIFO writes, observed mid-cycle.
  int clr_n = 0, en_n = 0, jd_n = 0, wr_n = 0;
  int clr_cyc = 0, en_cyc = 0, jd_cyc = 0, last_wr_cyc = 0;
  logic [DW-1:0] act_q [DIM+1][$];

  always @(negedge clk) begin
    if (rst_n) begin
      logic ld, hs;
      int t;
      logic [DIM:0] exp_wren;
      ld = (m_phase == 2);
      t  = tgt_of(m_k);
      hs = ld && !fifo_full[t] && in_valid;
      exp_wren = '0;
      if (hs) exp_wren[t] = 1'b1;
      check("in_ready", 32'(in_ready), 32'(ld && !fifo_full[t]));
      check("fifo_wren", 32'(fifo_wren), 32'(exp_wren));
      check("fifo_wdata", 32'(fifo_wdata), ld ? 32'(in_data) : 32'd0);
      check("mult_clr", 32'(mult_clr), 32'(m_phase == 1));
      check("mult_en", 32'(mult_en), 32'(m_phase == 3));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("job_done", 32'(job_done), 32'(m_phase == 4 && m_wait >= 1 && mult_done));
      if (mult_clr) begin clr_n++; clr_cyc = cyc; end
      if (mult_en)  begin en_n++;  en_cyc  = cyc; end
      if (job_done) begin jd_n++;  jd_cyc  = cyc; end
      for (int b = 0; b <= DIM; b++)
        if (fifo_wren[b]) begin
          act_q[b].push_back(fifo_wdata);
          wr_n++;
          last_wr_cyc = cyc;
        end
    end
  end

  logic [DW-1:0] src [TOTAL];
  int idx;

  task automatic run_job(input bit ident, input int valid_pct, input int full_mode,
                         input bit done_late, input bit extra_start, input bit abort);
    int b_clr, b_en, b_jd, b_wr, start_cyc, bp_left;
    int b_sz [DIM+1];
    bit finished, aborted, s1_done, s2_done;
    b_clr = clr_n; b_en = en_n; b_jd = jd_n; b_wr = wr_n;
    for (int i = 0; i <= DIM; i++) b_sz[i] = act_q[i].size();
    for (int i = 0; i < TOTAL; i++) src[i] = ident ? DW'(i) : DW'($urandom);
    idx = 0; finished = 0; aborted = 0; s1_done = 0; s2_done = 0; bp_left = 5;

    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    if (done_late) mult_done = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (jd_n != b_jd) begin finished = 1; break; end
      @(posedge clk); #1;
      start = 1'b0;
      if (abort && idx == 4 * DIM + 3) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      if (extra_start && !s1_done && idx == 20) begin start = 1'b1; s1_done = 1; end
      if (extra_start && !s2_done && en_n != b_en) begin start = 1'b1; s2_done = 1; end
      in_valid = ($urandom_range(99) < valid_pct);
      in_data  = src[(idx < TOTAL) ? idx : 0];
      fifo_full = '0;
      if (full_mode == 1) begin
        if (idx == 2 * DIM + 3 && bp_left > 0) begin fifo_full[3] = 1'b1; bp_left--; end
        if (idx < 5 * DIM) fifo_full[6] = 1'b1;
        if (idx < NA) fifo_full[0] = 1'b1;
      end else if (full_mode == 2) begin
        for (int b = 0; b <= DIM; b++) fifo_full[b] = ($urandom_range(3) == 0);
      end
      if (done_late && en_n != b_en && cyc == en_cyc + 10) mult_done = 1'b1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    fifo_full = '0;

    if (abort) begin
      check("abort_reached", 32'(aborted), 32'd1);
      @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_wren", 32'(fifo_wren), 32'd0);
      check("post_reset_ready", 32'(in_ready), 32'd0);
      check("post_reset_clr_en", 32'({mult_clr, mult_en, job_done}), 32'd0);
      return;
    end

    check("job_complete", 32'(finished), 32'd1);
    check("clr_count", 32'(clr_n - b_clr), 32'd1);
    check("en_count", 32'(en_n - b_en), 32'd1);
    check("jd_count", 32'(jd_n - b_jd), 32'd1);
    check("write_count", 32'(wr_n - b_wr), 32'(TOTAL));
    check("clr_latency", 32'(clr_cyc - start_cyc), 32'd1);
    check("en_after_last_wr", 32'(en_cyc - last_wr_cyc), 32'd1);
    check("done_latency", 32'(jd_cyc - en_cyc), done_late ? 32'd10 : 32'd2);
    for (int f = 0; f <= DIM; f++) begin
      check("fifo_count", 32'(act_q[f].size() - b_sz[f]), 32'(DIM));
      for (int j = 0; j < DIM && b_sz[f] + j < act_q[f].size(); j++)
        check("fifo_content", 32'(act_q[f][b_sz[f] + j]),
              32'(src[(f == 0) ? (NA + j) : ((f - 1) * DIM + j)]));
    end
    if (ident) begin
      check("lit_a2_5", 32'(act_q[3][b_sz[3] + 5]), 32'h15);
      check("lit_a7_7", 32'(act_q[8][b_sz[8] + 7]), 32'h3f);
      check("lit_b_0", 32'(act_q[0][b_sz[0]]), 32'h40);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    fifo_full = '0; mult_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", 32'({in_ready, mult_clr, mult_en, job_done}), 32'd0);
    check("reset_wren", 32'(fifo_wren), 32'd0);

    run_job(1, 100, 0, 0, 0, 0);  // basic job, stale done held high
    run_job(1, 100, 1, 1, 0, 0);  // backpressure on row 2, late done
    run_job(1, 50, 0, 0, 0, 0);   // bubbles
    run_job(0, 70, 2, 1, 1, 0);   // start pulses while busy
    run_job(0, 50, 2, 0, 0, 0);   // back-to-back after job_done
    run_job(1, 100, 0, 0, 0, 1);  // reset at row 4, col 3
    run_job(1, 60, 2, 0, 0, 0);   // fresh full load after reset
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mat_fifo_loader.md
Name: mat_fifo_loader

Overview:
- Producer side of the matrix-vector multiplier's FIFO interface: accepts a byte stream and writes it into the nine operand FIFOs.
  - FIFO 1..8: rows of A.
  - FIFO 0: vector B.
- Sequences the multiplier: clears the accumulators, fires the enable once both operands are loaded, then waits for the multiplier's done.
- Sits between the host/memory streaming source and the FIFO bank that feeds the multiplier.

Parameters:
- DATA_W, 8, operand byte width (data bus and FIFO write width).
- DIM, 8, matrix dimension; DIM rows of A, DIM elements per row, DIM elements of B.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin one load+multiply job; sampled only in IDLE.
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  stream byte valid.
- in_ready  output  1  loader accepts in_data this cycle.
- fifo_wdata  output  DATA_W  shared write data to all FIFOs.
- fifo_wren  output  DIM+1  one-hot write enable; bit 0 = B FIFO, bit r+1 = A row r FIFO.
- fifo_full  input  DIM+1  per-FIFO full flags, same bit mapping.
- mult_clr  output  1  one-cycle accumulator clear to the multiplier.
- mult_en  output  1  one-cycle start pulse to the multiplier.
- mult_done  input  1  multiplier done (all FIFOs drained, registered).
- busy  output  1  high in every state except IDLE.
- job_done  output  1  one-cycle pulse when a job completes.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, row=0, col=0. All outputs 0 (in_ready, fifo_wren, mult_clr, mult_en, busy, job_done). Reset mid-job abandons it; bytes already written remain in the FIFOs and are not the loader's concern.
- States: IDLE, CLEAR, LOAD_A, LOAD_B, FIRE, WAIT.
- IDLE: start=1 -> CLEAR. Other inputs ignored; in_ready=0.
- CLEAR: mult_clr=1 for exactly this cycle; row=0, col=0 -> LOAD_A.
- Write path, LOAD_A/LOAD_B only:
  - Target FIFO: t = row+1 in LOAD_A, t = 0 in LOAD_B.
  - in_ready = !fifo_full[t] (combinational).
  - Handshake = in_valid & in_ready.
  - On handshake, same cycle: fifo_wren[t]=1, fifo_wdata=in_data. fifo_wren is zero-latency and never has more than one bit set.
  - fifo_wdata = in_data whenever the state is LOAD_A or LOAD_B; 0 otherwise.
- LOAD_A: byte order is row-major, A[0][0..DIM-1], A[1][..], ... Each handshake increments col. col wraps DIM-1 -> 0 with row+1. The handshake at row=DIM-1, col=DIM-1 -> LOAD_B with col=0.
- LOAD_B: each handshake increments col. The handshake at col=DIM-1 -> FIRE.
- Stall: in_valid=0 or full target -> no write, counters hold. No timeout.
- FIRE: mult_en=1 for exactly this cycle; in_ready=0 -> WAIT.
- WAIT:
  - in_ready=0.
  - The first WAIT cycle ignores mult_done (guard against a stale done from before loading).
  - From the second cycle on, mult_done=1 -> IDLE, with job_done=1 for exactly that transition cycle.
- start asserted while busy=1: ignored, not queued.
- Counters: row, col are $clog2(DIM) bits wide; no overflow beyond DIM-1.
- Exact totals per job: DIM*DIM writes across FIFOs 1..DIM (DIM each), then DIM writes to FIFO 0.

Test Plan:
- Basic job, DIM=8: start, stream bytes 0x00..0x47 with in_valid held 1, FIFOs never full -> mult_clr one cycle after start, 72 single-cycle writes, FIFO r+1 receives 8r..8r+7, FIFO 0 receives 0x40..0x47, mult_en one cycle after the last write, busy=1 throughout.
- Backpressure: assert fifo_full[3] for 5 cycles while row=2 is mid-row -> in_ready=0 and no wren for those 5 cycles, counters hold, no byte lost or duplicated; the full flag of a non-target FIFO has no effect.
- Bubbles: random in_valid gaps (about 50%) -> identical FIFO contents to the basic job; every wren coincides with in_valid & in_ready.
- Done handshake: mult_done held 1 from reset, then job run -> no exit from WAIT in its first cycle. Drop then raise mult_done 10 cycles after FIRE -> job_done pulses once, busy falls the same cycle, state IDLE.
- start ignored: pulse start during LOAD_A and during WAIT -> no restart, no extra mult_clr or mult_en. Back-to-back jobs with start the cycle after job_done both complete correctly.
- Reset mid-operation: rst_n=0 at row=4, col=3 -> next cycle all outputs 0, busy=0. A fresh start then yields a full 72-byte load from row 0, col 0.
